ex_muldiv: RTL and testbench
============================

# ex_muldiv

Parametrised multi-cycle RV32M execution unit for the EX stage. It takes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operations from EX and runs them with a fixed-latency multiplier and an iterative divider. The result is held until EX consumes it. EX stalls (`ex_pipe_ready` low) while `mdu_busy` is high, the same way it stalls on a pending data-RAM access; EX flush cancels the operation.

## Interface
- `XLEN`, 32: operand/result width; must be even, ≥8.
- `MUL_LATENCY`, 2: cycles from accept to `mdu_done` for multiplies; ≥1.
- `DIV_BITS`, 1: quotient bits retired per divider cycle; one of 1, 2, 4; must divide `XLEN`.

- `clk` in 1: clock.
- `rst_b` in 1: synchronous, active-low reset.
- `mdu_req` in 1: operation request; sampled only in IDLE, or in DONE together with `mdu_ack`.
- `mdu_opcode` in 3: RV32M funct3 (000 MUL … 111 REMU).
- `mdu_src1` in XLEN: rs1 value.
- `mdu_src2` in XLEN: rs2 value.
- `mdu_flush` in 1: cancel the in-flight or held operation.
- `mdu_ack` in 1: EX has consumed the result; meaningful only while `mdu_done`.
- `mdu_busy` out 1: operation accepted and not yet acknowledged or flushed.
- `mdu_done` out 1: `mdu_result` is valid; held until ack or flush.
- `mdu_result` out XLEN: result.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE + `mdu_req` & ~`mdu_flush`:
  - Latch opcode and operands.
  - Go to MUL for funct3[2]=0.
  - Go to DONE for a divide special case.
  - Otherwise go to DIV.
- Divide special cases:
  - Divisor 0: quotient all-ones; remainder = src1.
  - Signed overflow (src1 = 1 followed by zeros, src2 = all-ones, DIV/REM only): quotient = src1; remainder = 0.
- MUL state:
  - Form the 2·XLEN-bit product of sign/zero-extended operands.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
  - Signedness: MULH s×s, MULHSU s×u, MULHU u×u.
  - A down-counter loaded with `MUL_LATENCY-1` moves the FSM to DONE at 0. Product pipelining/retiming is free as long as the latency is met.
- DIV state:
  - Restoring divide on magnitudes. Signed ops take absolute values at accept.
  - `XLEN/DIV_BITS` iterations, `DIV_BITS` quotient bits per cycle.
  - Counter is `$clog2(XLEN/DIV_BITS)+1` bits wide.
  - Last iteration moves the FSM to FIX.
- FIX state, one cycle:
  - Quotient negated if operand signs differ (signed ops).
  - Remainder takes the dividend's sign.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU).
  - Go to DONE.
- DONE:
  - `mdu_done`=1; result is stable.
  - `mdu_ack` & ~`mdu_req` → IDLE.
  - `mdu_ack` & `mdu_req` → accept the new operation directly, with the same branching as IDLE. Back-to-back issue has no bubble.
- `mdu_flush` in any state → IDLE next cycle and `mdu_done`=0. Flush wins over req and ack in the same cycle.
- `mdu_busy` = (state ≠ IDLE).

## Timing
- Reset values: state IDLE, `mdu_busy` 0, `mdu_done` 0, `mdu_result` 0, counters 0.
- Accept in cycle 0. Then:
  - Multiplies: `mdu_done` rises in cycle `MUL_LATENCY`.
  - Normal divides: `mdu_done` rises in cycle `XLEN/DIV_BITS + 2`. Defaults give 34.
  - Special-case divides: `mdu_done` rises in cycle 1.
- `mdu_result` is registered. It changes only on entry to DONE and is otherwise constant.
- Operands are latched at accept, so EX may change `mdu_src*` after cycle 0.
- `mdu_req` in MUL/DIV/FIX is ignored. No queueing.
- Reset mid-operation: IDLE next cycle; no `mdu_done`.
- Flush in the same cycle DONE would be entered: DONE is not entered and `mdu_done` never rises.

## Structure
- Shared package additions:
  - `MDU_OP_MUL`…`MDU_OP_REMU` funct3 constants.
  - `mdu_state_t` enum {IDLE, MUL, DIV, FIX, DONE}.
  - Function `mdu_is_div(funct3)`.
- Sub-module `mdu_divider`: unsigned iterative divider, parameters `XLEN` and `DIV_BITS`.
  - Inputs: start, dividend, divisor, flush.
  - Outputs: quotient, remainder, last.
- Sign handling, special cases and the FSM stay in `ex_muldiv`.

## Test plan
- MUL 7 × 0xFFFFFFFD with MUL_LATENCY=2 → `mdu_done` in cycle 2, result 0xFFFFFFEB. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD in cycle 34. REM same operands → 0xFFFFFFFF. REMU 100 / 7 → 2. Repeat with DIV_BITS=2 and 4 → done in cycles 18 and 10.
- DIVU 0x1234 / 0 → 0xFFFFFFFF. REM 0x1234 / 0 → 0x1234. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM of the same → 0. All done in cycle 1.
- DIV issued, `mdu_flush` in cycle 5 → `mdu_busy` 0 in cycle 6 and no `mdu_done`. A following MUL 3 × 4 → 12 with correct latency.
- Hold `mdu_ack` low for 10 cycles after done → `mdu_result` and `mdu_done` stable. Then ack together with a new req MULHU → `mdu_done` low next cycle, new result on time.
- `rst_b` low mid-divide → all outputs 0 the next cycle. A subsequent DIVU 10 / 3 → 3.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit.
// Funct3 encodings, FSM state type and small opcode decode helpers.
package ex_muldiv_pkg;

    localparam logic [2:0] MDU_OP_MUL    = 3'b000;
    localparam logic [2:0] MDU_OP_MULH   = 3'b001;
    localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
    localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
    localparam logic [2:0] MDU_OP_DIV    = 3'b100;
    localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
    localparam logic [2:0] MDU_OP_REM    = 3'b110;
    localparam logic [2:0] MDU_OP_REMU   = 3'b111;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} mdu_state_t;

    function automatic logic mdu_is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    // DIV and REM treat their operands as two's complement; DIVU/REMU do not.
    function automatic logic mdu_is_signed_div(input logic [2:0] funct3);
        return funct3[2] & ~funct3[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_divider.sv
// Unsigned iterative restoring divider, DIV_BITS quotient bits per cycle.
// Runs XLEN/DIV_BITS iterations after start; last flags the final one.
module mdu_divider #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int STEPS = XLEN / DIV_BITS;
    localparam int CNT_W = $clog2(STEPS) + 1;

    logic [XLEN-1:0]  quo_q, rem_q, div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  quo_step, rem_step;
    logic [XLEN:0]    trial;

    // quo_q doubles as the dividend shift register: dividend bits leave the
    // top while quotient bits enter at the bottom.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        quo_step = quo_q;
        rem_step = rem_q;
        trial    = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            trial = {rem_step, quo_step[XLEN-1]} - {1'b0, div_q};
            if (!trial[XLEN]) begin
                rem_step = trial[XLEN-1:0];
            end else begin
                rem_step = {rem_step[XLEN-2:0], quo_step[XLEN-1]};
            end
            quo_step = {quo_step[XLEN-2:0], ~trial[XLEN]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; the datapath
        // registers are reset too so the block leaves reset fully defined.
        if (!rst_b) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            div_q <= divisor;
            cnt_q <= CNT_W'(STEPS);
        end else if (cnt_q != '0) begin
            quo_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ex_muldiv.sv
// RV32M execution unit for EX: fixed-latency multiply, iterative divide,
// result held in DONE until EX acknowledges it or flushes.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            mdu_req,
    input  logic [2:0]      mdu_opcode,
    input  logic [XLEN-1:0] mdu_src1,
    input  logic [XLEN-1:0] mdu_src2,
    input  logic            mdu_flush,
    input  logic            mdu_ack,
    output logic            mdu_busy,
    output logic            mdu_done,
    output logic [XLEN-1:0] mdu_result
);

    localparam int              MUL_CNT_W = $clog2(MUL_LATENCY) + 1;
    localparam logic [XLEN-1:0] ALL_ONES  = '1;
    localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t           state_q, state_next;
    logic [2:0]           op_q;
    logic [XLEN-1:0]      a_q, b_q, result_q, result_next;
    logic                 neg_quo_q, neg_rem_q;
    logic [MUL_CNT_W-1:0] mul_cnt_q;

    logic            accept, result_load, div_start;
    logic            signed_div, div_by_zero, div_ovf, div_special;
    logic [XLEN-1:0] special_value, fix_value, dividend_abs, divisor_abs;
    logic [XLEN-1:0] div_quo, div_rem, quo_fixed, rem_fixed;
    logic            div_last;

    function automatic logic [XLEN-1:0] mul_value(input logic [2:0]      op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] a_ext, b_ext, prod;
        logic              a_signed, b_signed;
        a_signed = (op != MDU_OP_MULHU);
        b_signed = (op == MDU_OP_MUL) || (op == MDU_OP_MULH);
        a_ext    = {{XLEN{a_signed & a[XLEN-1]}}, a};
        b_ext    = {{XLEN{b_signed & b[XLEN-1]}}, b};
        prod     = a_ext * b_ext;
        return (op == MDU_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    // Accept-time decode always looks at the live request inputs.
    always_comb begin
        signed_div    = mdu_is_signed_div(mdu_opcode);
        div_by_zero   = (mdu_src2 == '0);
        div_ovf       = signed_div && (mdu_src1 == MIN_INT) && (mdu_src2 == ALL_ONES);
        div_special   = mdu_is_div(mdu_opcode) && (div_by_zero || div_ovf);
        special_value = mdu_opcode[1] ? (div_by_zero ? mdu_src1 : '0)
                                      : (div_by_zero ? ALL_ONES : mdu_src1);
        dividend_abs  = (signed_div && mdu_src1[XLEN-1]) ? -mdu_src1 : mdu_src1;
        divisor_abs   = (signed_div && mdu_src2[XLEN-1]) ? -mdu_src2 : mdu_src2;
        quo_fixed     = neg_quo_q ? -div_quo : div_quo;
        rem_fixed     = neg_rem_q ? -div_rem : div_rem;
        fix_value     = op_q[1] ? rem_fixed : quo_fixed;
    end

    always_comb begin
        state_next  = state_q;
        accept      = 1'b0;
        result_load = 1'b0;
        result_next = result_q;
        case (state_q)
            IDLE: accept = mdu_req;
            MUL: begin
                if (mul_cnt_q == MUL_CNT_W'(1)) begin
                    state_next  = DONE;
                    result_load = 1'b1;
                    result_next = mul_value(op_q, a_q, b_q);
                end
            end
            DIV: if (div_last) state_next = FIX;
            FIX: begin
                state_next  = DONE;
                result_load = 1'b1;
                result_next = fix_value;
            end
            DONE: begin
                if (mdu_ack) begin
                    state_next = IDLE;
                    accept     = mdu_req;
                end
            end
            default: state_next = IDLE;
        endcase

        if (accept) begin
            if (!mdu_is_div(mdu_opcode)) begin
                // A single-cycle multiply has no MUL state to wait in.
                if (MUL_LATENCY == 1) begin
                    state_next  = DONE;
                    result_load = 1'b1;
                    result_next = mul_value(mdu_opcode, mdu_src1, mdu_src2);
                end else begin
                    state_next = MUL;
                end
            end else if (div_special) begin
                state_next  = DONE;
                result_load = 1'b1;
                result_next = special_value;
            end else begin
                state_next = DIV;
            end
        end

        // Flush overrides everything decided above, including a DONE entry.
        if (mdu_flush) begin
            state_next  = IDLE;
            accept      = 1'b0;
            result_load = 1'b0;
        end
    end

    assign div_start = accept && mdu_is_div(mdu_opcode) && !div_special;

    always_ff @(posedge clk) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mul_cnt_q <= '0;
            result_q  <= '0;
        end else begin
            if (result_load) result_q <= result_next;
            if (accept) begin
                op_q      <= mdu_opcode;
                a_q       <= mdu_src1;
                b_q       <= mdu_src2;
                neg_quo_q <= signed_div & (mdu_src1[XLEN-1] ^ mdu_src2[XLEN-1]);
                neg_rem_q <= signed_div & mdu_src1[XLEN-1];
            end
            // The counter reaches zero on the same edge that enters DONE.
            if (mdu_flush)                            mul_cnt_q <= '0;
            else if (accept && state_next == MUL)     mul_cnt_q <= MUL_CNT_W'(MUL_LATENCY - 1);
            else if (state_q == MUL && mul_cnt_q != '0) mul_cnt_q <= mul_cnt_q - 1'b1;
        end
    end

    mdu_divider #(
        .XLEN     (XLEN),
        .DIV_BITS (DIV_BITS)
    ) u_divider (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (div_start),
        .dividend  (dividend_abs),
        .divisor   (divisor_abs),
        .flush     (mdu_flush),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    assign mdu_busy   = (state_q != IDLE);
    assign mdu_done   = (state_q == DONE);
    assign mdu_result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: three instances cover DIV_BITS 1, 2 and 4;
// cycle numbers count from the accept edge (cycle 1 is the first after it).
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  ack = '0;
    logic [2:0]  opcode = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic [2:0]  busy, done;
    logic [31:0] result [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .MUL_LATENCY(2), .DIV_BITS(1)) dut0 (
        .clk(clk), .rst_b(rst_b), .mdu_req(req[0]), .mdu_opcode(opcode),
        .mdu_src1(src1), .mdu_src2(src2), .mdu_flush(flush), .mdu_ack(ack[0]),
        .mdu_busy(busy[0]), .mdu_done(done[0]), .mdu_result(result[0]));

    ex_muldiv #(.XLEN(32), .MUL_LATENCY(2), .DIV_BITS(2)) dut1 (
        .clk(clk), .rst_b(rst_b), .mdu_req(req[1]), .mdu_opcode(opcode),
        .mdu_src1(src1), .mdu_src2(src2), .mdu_flush(flush), .mdu_ack(ack[1]),
        .mdu_busy(busy[1]), .mdu_done(done[1]), .mdu_result(result[1]));

    ex_muldiv #(.XLEN(32), .MUL_LATENCY(2), .DIV_BITS(4)) dut2 (
        .clk(clk), .rst_b(rst_b), .mdu_req(req[2]), .mdu_opcode(opcode),
        .mdu_src1(src1), .mdu_src2(src2), .mdu_flush(flush), .mdu_ack(ack[2]),
        .mdu_busy(busy[2]), .mdu_done(done[2]), .mdu_result(result[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge of cycle 1 with inputs scrambled,
    // so any result depending on live operands shows up.
    task automatic issue(input int sel, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        req[sel] = 1'b1;
        opcode   = op;
        src1     = a;
        src2     = b;
        @(negedge clk);
        req[sel] = 1'b0;
        opcode   = op ^ 3'b101;
        src1     = 32'hDEADBEEF;
        src2     = 32'h0BADF00D;
    endtask

    task automatic wait_done(input int sel, input int exp_cyc, input string tag);
        int cyc = 1;
        while (done[sel] !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic ack_result(input int sel, input string tag);
        @(negedge clk);
        ack[sel] = 1'b1;
        @(negedge clk);
        ack[sel] = 1'b0;
        check({tag, " done after ack"}, {31'd0, done[sel]}, 32'd0);
    endtask

    task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_cyc, input string tag);
        issue(sel, op, a, b);
        wait_done(sel, exp_cyc, tag);
        check({tag, " result"}, result[sel], exp_res);
        ack_result(sel, tag);
    endtask

    initial begin
        int bad;
        int rises;

        repeat (3) @(negedge clk);
        check("reset busy", {29'd0, busy}, 32'd0);
        check("reset done", {29'd0, done}, 32'd0);
        check("reset result0", result[0], 32'd0);
        check("reset result2", result[2], 32'd0);
        rst_b = 1'b1;

        run_op(0, MDU_OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2, "mul");
        run_op(0, MDU_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2, "mulh");
        run_op(0, MDU_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, "mulhsu");

        // Hold the result with ack low, then ack together with a new request.
        issue(0, MDU_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, 2, "mulhu");
        check("mulhu result", result[0], 32'hFFFFFFFE);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done[0] !== 1'b1 || result[0] !== 32'hFFFFFFFE) bad++;
        end
        check("hold unstable cycles", 32'(bad), 32'd0);
        @(negedge clk);
        ack[0] = 1'b1;
        req[0] = 1'b1;
        opcode = MDU_OP_MULHU;
        src1   = 32'h00010000;
        src2   = 32'h00030000;
        @(negedge clk);
        ack[0] = 1'b0;
        req[0] = 1'b0;
        src1   = 32'hDEADBEEF;
        check("b2b done low", {31'd0, done[0]}, 32'd0);
        check("b2b busy", {31'd0, busy[0]}, 32'd1);
        wait_done(0, 2, "b2b mulhu");
        check("b2b mulhu result", result[0], 32'd3);
        ack_result(0, "b2b mulhu");

        run_op(0, MDU_OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div");
        run_op(0, MDU_OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem");
        run_op(0, MDU_OP_REMU, 32'd100,      32'd7, 32'd2,        34, "remu");
        run_op(1, MDU_OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 18, "div x2");
        run_op(1, MDU_OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 18, "rem x2");
        run_op(2, MDU_OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 10, "div x4");
        run_op(2, MDU_OP_REMU, 32'd100,      32'd7, 32'd2,        10, "remu x4");

        run_op(0, MDU_OP_DIVU, 32'h1234,     32'd0,        32'hFFFFFFFF, 1, "divu by 0");
        run_op(0, MDU_OP_REM,  32'h1234,     32'd0,        32'h1234,     1, "rem by 0");
        run_op(0, MDU_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div ovf");
        run_op(0, MDU_OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1, "rem ovf");

        // Flush a divide in cycle 5.
        issue(0, MDU_OP_DIV, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'd0, busy[0]}, 32'd0);
        rises = 0;
        repeat (40) begin
            @(negedge clk);
            if (done[0] === 1'b1) rises++;
        end
        check("flush no done", 32'(rises), 32'd0);
        run_op(0, MDU_OP_MUL, 32'd3, 32'd4, 32'd12, 2, "mul after flush");

        // Flush in the cycle DONE would have been entered.
        issue(0, MDU_OP_MUL, 32'd5, 32'd6);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("late flush done", {31'd0, done[0]}, 32'd0);
        check("late flush busy", {31'd0, busy[0]}, 32'd0);
        check("late flush result", result[0], 32'd12);

        // Reset in the middle of a divide.
        issue(0, MDU_OP_DIVU, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        check("mid reset busy", {31'd0, busy[0]}, 32'd0);
        check("mid reset done", {31'd0, done[0]}, 32'd0);
        check("mid reset result", result[0], 32'd0);
        rst_b = 1'b1;
        run_op(0, MDU_OP_DIVU, 32'd10, 32'd3, 32'd3, 34, "divu after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
